// File: rtl/div_if.sv
// Execute-stage <-> divider handshake: operands and start/annul in, {HI,LO} result and ready out.
interface div_if;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider, one iteration per clock, result {rem, quo}.
// Define DIV_SIGNED_EN to enable the signed (DIV) path; otherwise every operation is unsigned.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;

    logic [32:0] div_temp;
    logic [64:0] div_step;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Partial remainder sits in dividend[63:32]; it never needs bit 64 because
    // a prefix of a 32-bit dividend is below 2^31 until the final step.
    assign div_temp = {1'b0, dividend[63:32]} - {1'b0, divisor};
    assign div_step = div_temp[32] ? {dividend[63:0], 1'b0}
                                   : {div_temp[31:0], dividend[31:0], 1'b1};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign op1_mag = (bus.signed_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign op2_mag = (bus.signed_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    assign quo_fix = neg_q ? (~div_step[31:0] + 32'd1)  : div_step[31:0];
    assign rem_fix = neg_r ? (~div_step[64:33] + 32'd1) : div_step[64:33];
`else
    logic unused_signed;

    assign unused_signed = bus.signed_i;
    assign op1_mag       = bus.opdata1_i;
    assign op2_mag       = bus.opdata2_i;
    assign quo_fix       = div_step[31:0];
    assign rem_fix       = div_step[64:33];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 6'd0;
            dividend    <= 65'd0;
            divisor     <= 32'd0;
            bus.ready_o <= 1'b0;
            bus.result_o <= 64'd0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= 64'd0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            dividend <= {32'd0, op1_mag, 1'b0};
                            divisor  <= op2_mag;
                            cnt      <= 6'd0;
`ifdef DIV_SIGNED_EN
                            neg_q    <= bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                            neg_r    <= bus.signed_i & bus.opdata1_i[31];
`endif
                            state    <= ON;
                        end
                    end
                end
                BYZERO: begin
                    dividend <= 65'd0;
                    state    <= END;
                end
                ON: begin
                    if (bus.annul_i) begin
                        cnt   <= 6'd0;
                        state <= IDLE;
                    end else if (cnt == 6'd31) begin
                        // Final iteration lands sign-corrected in the same layout END reads.
                        dividend <= {rem_fix, 1'b0, quo_fix};
                        cnt      <= 6'd0;
                        state    <= END;
                    end else begin
                        dividend <= div_step;
                        cnt      <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (bus.start_i) begin
                        bus.result_o <= {dividend[64:33], dividend[31:0]};
                        bus.ready_o  <= 1'b1;
                    end else begin
                        bus.result_o <= 64'd0;
                        bus.ready_o  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: directed cases plus randomized operands against an arithmetic model.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    div_if bus ();

    div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        bit sg;
        sg = s;
`ifndef DIV_SIGNED_EN
        sg = 1'b0;
`endif
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: each rising ready must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ready_o && !prev_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ready: got result %h expected no response", bus.result_o);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result_o, e.res);
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
            prev_rdy = bus.ready_o;
        end
    end

    task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int hold, input bit scramble, input bit rst_end);
        exp_t e;
        int n;
        @(negedge clk);
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        e.res = exp;
        e.due = cyc + 1 + ((b == 32'd0) ? 2 : 33);
        sb.push_back(e);
        n = 0;
        while (!bus.ready_o && n < 50) begin
            @(negedge clk);
            n++;
            if (scramble && n == 5) begin
                bus.signed_i  = ~s;
                bus.opdata1_i = ~a;
                bus.opdata2_i = b ^ 32'h5A5A_0003;
            end
        end
        if (!bus.ready_o) begin
            checks++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_ready", 64'(bus.ready_o), 64'd1);
            chk("hold_result", bus.result_o, exp);
        end
        if (rst_end) rst = 1'b1;
        else bus.start_i = 1'b0;
        @(negedge clk);
        chk(rst_end ? "rst_end_ready" : "drop_ready", 64'(bus.ready_o), 64'd0);
        chk(rst_end ? "rst_end_result" : "drop_result", bus.result_o, 64'd0);
        rst = 1'b0;
        bus.start_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b;
        bit s;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 1'b0, 1'b0);
`ifdef DIV_SIGNED_EN
        run(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1, 1'b0, 1'b0);
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 1'b0, 1'b0);
`else
        run(1'b1, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 1, 1'b0, 1'b0);
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 0, 1'b0, 1'b0);
`endif
        run(1'b0, 32'h1234, 32'd0, 64'd0, 0, 1'b0, 1'b0);

        // Annul at iteration 10: no response may appear.
        @(negedge clk);
        bus.signed_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5; bus.start_i = 1'b1;
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("annul_no_ready", 64'(bus.ready_o), 64'd0);
        run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0, 1'b0, 1'b0);

        // Reset mid-iteration.
        @(negedge clk);
        bus.opdata1_i = 32'd77; bus.opdata2_i = 32'd4; bus.start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        rst = 1'b0; bus.start_i = 1'b0;
        run(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 0, 1'b0, 1'b1);
        run(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, 1'b0, 1'b0);

        // Operands disturbed mid-iteration, result held for 5 extra cycles.
        run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 5, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 15);
                1: b = $urandom;
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 1000);
            endcase
            run(s, a, b, model(s, a, b), $urandom_range(0, 2), 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
